// File: rtl/frame_stream_receiver.sv
// Captures 64-pixel serial frames into a capture buffer, commits finished frames
// to a display buffer, and scans the display buffer onto an 8x8 row-multiplexed matrix.
module frame_stream_receiver #(
    parameter int START_DELAY = 2,
    parameter int SCAN_DIV    = 16,
    parameter int PIX_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pixel_data,
    input  logic             frame_start,
    output logic [7:0]       row_sel,
    output logic [7:0]       col_data,
    output logic             frame_done,
    output logic             frame_abort,
    output logic [7:0]       frame_count,
    output logic [1:0]       state_dbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, CAPTURE = 2'd2} state_t;

    localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DLY_LOAD = DW'(START_DELAY - 1);
    localparam logic [SW-1:0] DIV_MAX  = SW'(SCAN_DIV - 1);

    state_t        state, state_nxt;
    logic [DW-1:0] dly, dly_nxt;
    logic [5:0]    idx, idx_nxt;
    logic [63:0]   cap, cap_nxt;
    logic [63:0]   disp, disp_nxt;
    logic          done_nxt, abort_nxt;
    logic [7:0]    count_nxt;
    logic [SW-1:0] div, div_nxt;
    logic [2:0]    row_idx, row_idx_nxt;
    logic          lit;

    assign lit       = |pixel_data;
    assign state_dbg = state;

    // Next-state and datapath. Bit k of cap/disp is pixel k: row k[5:3], column k[2:0].
    always_comb begin
        state_nxt = state;
        dly_nxt   = dly;
        idx_nxt   = idx;
        cap_nxt   = cap;
        disp_nxt  = disp;
        done_nxt  = 1'b0;
        abort_nxt = 1'b0;
        count_nxt = frame_count;

        case (state)
            WAIT: begin
                if (dly <= DW'(1)) begin
                    state_nxt = CAPTURE;
                    idx_nxt   = 6'd0;
                end else begin
                    dly_nxt = dly - DW'(1);
                end
            end
            CAPTURE: begin
                cap_nxt[idx] = lit;
                if (idx == 6'd63) begin
                    disp_nxt  = cap_nxt;
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    count_nxt = frame_count + 8'd1;
                end else begin
                    idx_nxt = idx + 6'd1;
                end
            end
            default: ;
        endcase

        // A new frame always wins; only a frame short of its last pixel is aborted.
        if (frame_start) begin
            if (state == WAIT || (state == CAPTURE && idx != 6'd63)) begin
                abort_nxt = 1'b1;
            end
            cap_nxt = '0;
            idx_nxt = 6'd0;
            if (START_DELAY == 1) begin
                state_nxt = CAPTURE;
            end else begin
                state_nxt = WAIT;
                dly_nxt   = DLY_LOAD;
            end
        end
    end

    always_comb begin
        div_nxt     = div + SW'(1);
        row_idx_nxt = row_idx;
        if (div == DIV_MAX) begin
            div_nxt     = '0;
            row_idx_nxt = row_idx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // col_data is loaded from the post-edge buffer so a commit shows with frame_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            dly         <= '0;
            idx         <= 6'd0;
            cap         <= '0;
            disp        <= '0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            frame_count <= 8'd0;
            div         <= '0;
            row_idx     <= 3'd0;
            row_sel     <= 8'h01;
            col_data    <= 8'h00;
        end else begin
            dly         <= dly_nxt;
            idx         <= idx_nxt;
            cap         <= cap_nxt;
            disp        <= disp_nxt;
            frame_done  <= done_nxt;
            frame_abort <= abort_nxt;
            frame_count <= count_nxt;
            div         <= div_nxt;
            row_idx     <= row_idx_nxt;
            row_sel     <= 8'b1 << row_idx_nxt;
            col_data    <= disp_nxt[{row_idx_nxt, 3'b000} +: 8];
        end
    end
endmodule
